deinterleaver: RTL
==================

DEINTERLEAVER -- requirements
Module: deinterleaver

Interface
REQ-001 SHALL expose parameter Ncbps, default 192, coded bits per block.
REQ-002 SHALL expose parameter Ncpc, default 2, coded bits per carrier (QPSK).
REQ-003 SHALL expose parameter s, default Ncpc/2, permutation group size.
REQ-004 SHALL expose parameter d, default 16, interleaver column count.
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port resetN  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port valid_demod  input  1  data_in valid from the demapper.
REQ-008 SHALL have port data_in  input  1  received (interleaved) bit, block index j ascending.
REQ-009 SHALL have port ready_fec  input  1  downstream FEC decoder accepts data_out.
REQ-010 SHALL have port ready_deinterleaver  output  1  block may accept data_in this cycle.
REQ-011 SHALL have port valid_deinterleaver  output  1  data_out valid.
REQ-012 SHALL have port data_out  output  1  deinterleaved bit.
REQ-013 SHALL have port data_out_index  output  $clog2(Ncbps)  original index k of data_out.

Function
REQ-014 SHALL hold two Ncbps-bit banks (ping-pong), each with a registered full flag.
REQ-015 Write accept = valid_demod && ready_deinterleaver; ready_deinterleaver = NOT full[wr_bank], registered state only.
REQ-016 On accept, bit j SHALL be stored at bank position k(j); with s=1: k = d*j - (Ncbps-1)*floor(d*j/Ncbps); general s per the 802.16 two-step inverse.
REQ-017 Write counter j SHALL increment 0..Ncbps-1; on accept at Ncbps-1: set full[wr_bank], toggle wr_bank, wrap j to 0.
REQ-018 valid_deinterleaver SHALL equal full[rd_bank]; data_out = bank[rd_bank][rd_cnt]; data_out_index = rd_cnt.
REQ-019 Read advances on valid_deinterleaver && ready_fec; at rd_cnt = Ncbps-1: clear full[rd_bank], toggle rd_bank, wrap rd_cnt to 0.
REQ-020 Latency: first bit of a block SHALL be valid the cycle after its Ncbps-th bit is accepted.
REQ-021 Sustained throughput SHALL be 1 bit/cycle in and out with ready_fec held high; ready_deinterleaver never deasserts.
REQ-022 Both banks full: ready_deinterleaver low; data_in ignored; no bit lost or overwritten.
REQ-023 Bank freed by read in cycle t SHALL be writable from cycle t+1.
REQ-024 Simultaneous write-complete and read-complete on different banks SHALL both update flags in the same cycle.
REQ-025 No combinational path from any input to any output.
REQ-026 data_out/data_out_index SHALL hold stable while valid_deinterleaver && !ready_fec.

Reset
REQ-027 resetN low SHALL asynchronously clear: counters, wr_bank, rd_bank, full flags; outputs valid_deinterleaver=0, data_out=0, data_out_index=0; ready_deinterleaver=1 after release.
REQ-028 Reset mid-block SHALL discard partial and full blocks; bank contents need not be cleared.

Structure
REQ-029 Shared package wimax_pkg SHALL hold Ncbps/Ncpc/d defaults, index width type, and the k(j) index function shared with the interleaver.
REQ-030 Sub-module deinterleaver_index (combinational j -> k) SHALL be used; incremental k computation permitted if equivalent.

Verification
REQ-031 Reset, ready_fec=1, feed bits LSB-first of 192'h4B047DFA42F2A5D5F61C021A5851E9A309A24FD58086BD1E -> output bit at index k equals bit k of 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA, first valid one cycle after 192nd accept.
REQ-032 Single-one walk: only j=12 set -> only index 1 set; j=0 -> index 0; j=191 -> index 191.
REQ-033 ready_fec=0, stream continuously -> ready_deinterleaver drops after 384 accepts; release -> both blocks delivered intact in order.
REQ-034 Three back-to-back golden blocks, valid_demod and ready_fec constant high -> ready never drops, 576 contiguous correct outputs.
REQ-035 Reset asserted after 100 bits -> outputs at reset values; next full golden block deinterleaves correctly.
REQ-036 Random gaps on valid_demod and ready_fec -> output identical to REQ-031.

Source files
------------

// File: rtl/wimax_pkg.sv
// Shared 802.16 interleaver constants, bank/index types and the received-position to
// original-index map used by both the interleaver and the deinterleaver.
package wimax_pkg;

    localparam int NCBPS_DEF = 192;
    localparam int NCPC_DEF  = 2;
    localparam int D_DEF     = 16;
    localparam int IDX_W     = $clog2(NCBPS_DEF);

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {
        BANK_A = 1'b0,
        BANK_B = 1'b1
    } bank_e;

    // Two-step inverse permutation: undo the bit rotation inside each s-group, then the
    // row/column write order of the d-column interleaver matrix.
    function automatic int deintIndex(input int j, input int ncbps, input int s, input int d);
        int sEff;
        int m;
        sEff = (s < 1) ? 1 : s;
        m    = sEff * (j / sEff) + ((j + (d * j) / ncbps) % sEff);
        return d * m - (ncbps - 1) * ((d * m) / ncbps);
    endfunction

endpackage

// File: rtl/deinterleaver_if.sv
// Bit-serial handshake bundle: demapper -> deinterleaver -> FEC decoder.
interface deinterleaver_if #(
    parameter int Ncbps = wimax_pkg::NCBPS_DEF
);
    logic                     valid_demod;
    logic                     data_in;
    logic                     ready_fec;
    logic                     ready_deinterleaver;
    logic                     valid_deinterleaver;
    logic                     data_out;
    logic [$clog2(Ncbps)-1:0] data_out_index;

    modport master (
        output valid_demod, data_in, ready_fec,
        input  ready_deinterleaver, valid_deinterleaver, data_out, data_out_index
    );

    modport slave (
        input  valid_demod, data_in, ready_fec,
        output ready_deinterleaver, valid_deinterleaver, data_out, data_out_index
    );
endinterface

// File: rtl/deinterleaver_index.sv
// Combinational map from received block position j to original coded-bit index k.
module deinterleaver_index import wimax_pkg::*; #(
    parameter int  Ncbps = NCBPS_DEF,
    parameter int  s     = 1,
    parameter int  d     = D_DEF,
    localparam int IW    = $clog2(Ncbps)
) (
    input  logic [IW-1:0] i_j,
    output logic [IW-1:0] o_k
);

    always_comb begin
        o_k = IW'(deintIndex(int'(i_j), Ncbps, s, d));
    end

endmodule

// File: rtl/deinterleaver.sv
// Ping-pong block deinterleaver: one bank is filled at permuted positions while the other
// drains in original index order, giving one bit per cycle in and out.
module deinterleaver import wimax_pkg::*; #(
    parameter int  Ncbps = NCBPS_DEF,
    parameter int  Ncpc  = NCPC_DEF,
    parameter int  s     = Ncpc / 2,
    parameter int  d     = D_DEF,
    localparam int IW    = $clog2(Ncbps)
) (
    input logic            clk,
    input logic            resetN,
    deinterleaver_if.slave bus
);

    localparam logic [IW-1:0] LAST = IW'(Ncbps - 1);

    logic [IW-1:0]    r_wrCnt;
    logic [IW-1:0]    r_rdCnt;
    bank_e            r_wrBank;
    bank_e            r_rdBank;
    logic [1:0]       r_full;
    logic [Ncbps-1:0] r_bank [2];

    logic [IW-1:0]    w_k;
    logic             w_wrSel;
    logic             w_rdSel;
    logic             w_valid;
    logic             w_wrAcc;
    logic             w_rdAcc;
    logic             w_wrDone;
    logic             w_rdDone;
    logic [1:0]       w_setFull;
    logic [1:0]       w_clrFull;

    assign w_wrSel  = (r_wrBank == BANK_B);
    assign w_rdSel  = (r_rdBank == BANK_B);
    assign w_valid  = r_full[w_rdSel];
    assign w_wrAcc  = bus.valid_demod && !r_full[w_wrSel];
    assign w_rdAcc  = w_valid && bus.ready_fec;
    assign w_wrDone = w_wrAcc && (r_wrCnt == LAST);
    assign w_rdDone = w_rdAcc && (r_rdCnt == LAST);

    // A bank cannot complete a write and a read at once (write needs it empty, read needs
    // it full), so set and clear never collide on the same flag.
    assign w_setFull = {w_wrDone && w_wrSel, w_wrDone && !w_wrSel};
    assign w_clrFull = {w_rdDone && w_rdSel, w_rdDone && !w_rdSel};

    deinterleaver_index #(
        .Ncbps (Ncbps),
        .s     (s),
        .d     (d)
    ) u_index (
        .i_j (r_wrCnt),
        .o_k (w_k)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_wrCnt  <= '0;
            r_rdCnt  <= '0;
            r_wrBank <= BANK_A;
            r_rdBank <= BANK_A;
            r_full   <= 2'b00;
        end else begin
            if (w_wrAcc) begin
                r_wrCnt <= w_wrDone ? '0 : r_wrCnt + IW'(1);
            end
            if (w_wrDone) begin
                r_wrBank <= (r_wrBank == BANK_A) ? BANK_B : BANK_A;
            end
            if (w_rdAcc) begin
                r_rdCnt <= w_rdDone ? '0 : r_rdCnt + IW'(1);
            end
            if (w_rdDone) begin
                r_rdBank <= (r_rdBank == BANK_A) ? BANK_B : BANK_A;
            end
            r_full <= (r_full | w_setFull) & ~w_clrFull;
        end
    end

    // Storage is deliberately left out of reset; the full flags decide what is meaningful.
    always_ff @(posedge clk) begin
        if (w_wrAcc) begin
            r_bank[w_wrSel][w_k] <= bus.data_in;
        end
    end

    assign bus.ready_deinterleaver = !r_full[w_wrSel];
    assign bus.valid_deinterleaver = w_valid;
    assign bus.data_out            = w_valid && r_bank[w_rdSel][r_rdCnt];
    assign bus.data_out_index      = r_rdCnt;

endmodule
